// File: rtl/sync_circular_fifo_if.sv
// Handshake/data bundle between a producer/consumer and sync_circular_fifo.
// The FIFO side uses the slave modport; the driving logic uses master.
interface sync_circular_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic [DATA_WIDTH-1:0] datainput;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dataoutput;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, datainput, push, pop,
    input  dataoutput, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, datainput, push, pop,
    output dataoutput, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_circular_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers, occupancy count,
// almost-full/empty thresholds, sticky error flags and synchronous flush.
module sync_circular_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic               clk,
  input logic               reset,
  sync_circular_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr, rptr, cnt;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dv, ovf, unf;
  logic                  full_w, empty_w, push_ok, pop_ok;

  // Status is derived only from registered pointers, never from push/pop.
  assign cnt     = wptr - rptr;
  assign full_w  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty_w = (wptr == rptr);

  // A pop frees a slot at a full edge; an empty FIFO never falls through.
  assign pop_ok  = bus.pop & ~empty_w;
  assign push_ok = bus.push & (~full_w | bus.pop);

  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && push_ok)
      mem[wptr[AW-1:0]] <= bus.datainput;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
      dv   <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (bus.flush) begin
      // Output register and RAM deliberately keep their contents.
      wptr <= '0;
      rptr <= '0;
      dv   <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      dv <= pop_ok;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr[AW-1:0]];
      end
      if (bus.push && !push_ok) ovf <= 1'b1;
      if (bus.pop && !pop_ok)   unf <= 1'b1;
    end
  end

  assign bus.dataoutput   = dout;
  assign bus.data_valid   = dv;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= AF_L);
  assign bus.almost_empty = (cnt <= AE_L);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
endmodule

// File: tb/tb_sync_circular_fifo.sv
// Directed bench for sync_circular_fifo (DEPTH=8, AF=6, AE=2): fill/drain,
// wrap, full/empty boundaries, flush and mid-stream reset.
module tb_sync_circular_fifo;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  sync_circular_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  sync_circular_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic op(input logic pu, input logic po, input logic [7:0] d);
    bus.push = pu;
    bus.pop = po;
    bus.datainput = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".dout"},  32'(bus.dataoutput), 0);
    chk({tag, ".dv"},    32'(bus.data_valid), 0);
    chk({tag, ".full"},  32'(bus.full), 0);
    chk({tag, ".empty"}, 32'(bus.empty), 1);
    chk({tag, ".af"},    32'(bus.almost_full), 0);
    chk({tag, ".ae"},    32'(bus.almost_empty), 1);
    chk({tag, ".count"}, 32'(bus.count), 0);
    chk({tag, ".ovf"},   32'(bus.overflow), 0);
    chk({tag, ".unf"},   32'(bus.underflow), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.datainput = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("rst");

    // Fill 0x10..0x17; almost_full rises with the 6th word.
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 1'b0, 8'(8'h10 + i));
      chk("fill.count", 32'(bus.count), 32'(i + 1));
      chk("fill.af", 32'(bus.almost_full), 32'((i + 1) >= 6));
      chk("fill.ae", 32'(bus.almost_empty), 32'((i + 1) <= 2));
    end
    chk("fill.full", 32'(bus.full), 1);

    // Push while full without pop is rejected.
    op(1'b1, 1'b0, 8'hEE);
    chk("ovf.flag", 32'(bus.overflow), 1);
    chk("ovf.count", 32'(bus.count), 8);

    // Push+pop at full: both accepted, count holds.
    op(1'b1, 1'b1, 8'h18);
    chk("fpp.dout", 32'(bus.dataoutput), 32'h10);
    chk("fpp.dv", 32'(bus.data_valid), 1);
    chk("fpp.count", 32'(bus.count), 8);
    chk("fpp.full", 32'(bus.full), 1);

    // Drain: 0x11..0x18 in order, 0xEE never stored.
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00);
      chk("drain.dout", 32'(bus.dataoutput), 32'(8'h11 + i));
      chk("drain.dv", 32'(bus.data_valid), 1);
    end
    chk("drain.empty", 32'(bus.empty), 1);
    chk("drain.count", 32'(bus.count), 0);

    op(1'b0, 1'b0, 8'h00);
    chk("idle.dv", 32'(bus.data_valid), 0);
    chk("idle.dout", 32'(bus.dataoutput), 32'h18);

    // Pop while empty.
    op(1'b0, 1'b1, 8'h00);
    chk("unf.flag", 32'(bus.underflow), 1);
    chk("unf.dv", 32'(bus.data_valid), 0);

    // Push+pop while empty: push only.
    op(1'b1, 1'b1, 8'h55);
    chk("epp.count", 32'(bus.count), 1);
    chk("epp.dv", 32'(bus.data_valid), 0);
    op(1'b0, 1'b1, 8'h00);
    chk("epp.dout", 32'(bus.dataoutput), 32'h55);
    chk("epp.dv2", 32'(bus.data_valid), 1);
    chk("epp.empty", 32'(bus.empty), 1);

    // Wrap-around: advance pointers by 5, then fill across the boundary.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 8'h00);
    chk("wrap.pre", 32'(bus.dataoutput), 32'h04);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'hA0 + i));
    chk("wrap.full", 32'(bus.full), 1);
    chk("wrap.count", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00);
      chk("wrap.dout", 32'(bus.dataoutput), 32'(8'hA0 + i));
    end
    chk("wrap.empty", 32'(bus.empty), 1);

    // Flush with 4 entries and sticky errors set; the push is ignored.
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'(8'h30 + i));
    chk("fl.precount", 32'(bus.count), 4);
    chk("fl.preovf", 32'(bus.overflow), 1);
    bus.flush = 1'b1;
    op(1'b1, 1'b0, 8'h99);
    bus.flush = 1'b0;
    chk("fl.count", 32'(bus.count), 0);
    chk("fl.empty", 32'(bus.empty), 1);
    chk("fl.ovf", 32'(bus.overflow), 0);
    chk("fl.unf", 32'(bus.underflow), 0);
    chk("fl.dv", 32'(bus.data_valid), 0);
    chk("fl.dout", 32'(bus.dataoutput), 32'hA7);
    op(1'b1, 1'b0, 8'h77);
    op(1'b0, 1'b1, 8'h00);
    chk("fl.after", 32'(bus.dataoutput), 32'h77);

    // Reset mid-stream while popping at count=3.
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'(8'h61 + i));
    op(1'b0, 1'b1, 8'h00);
    chk("mrst.pre", 32'(bus.count), 3);
    chk("mrst.dout", 32'(bus.dataoutput), 32'h61);
    reset = 1'b1;
    op(1'b0, 1'b1, 8'h00);
    reset = 1'b0;
    chk_reset_state("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
